// File: rtl/bp_dma_bram_mem.sv
// bp_dma_bram_mem: block-RAM responder for the bsg_cache DMA interface.
// Each DMA packet becomes a fixed-length, block-aligned read or write burst
// on the fill-data channels. One packet is in flight at a time.
// Optional feature: define BP_DMA_BRAM_MEM_RANGE_CHECK_EN to flag packets
// addressing beyond the RAM (sticky error_o, reads return zeros, writes are
// dropped). Without it, upper address bits alias and error_o is tied to 0.
module bp_dma_bram_mem #(
  parameter int addr_width_p = 28,
  parameter int fill_width_p = 64,
  parameter int burst_len_p  = 8,
  parameter int mem_els_p    = 1024
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [addr_width_p:0]   dma_pkt_i,
  input  logic                    dma_pkt_v_i,
  output logic                    dma_pkt_yumi_o,
  output logic [fill_width_p-1:0] dma_data_o,
  output logic                    dma_data_v_o,
  input  logic                    dma_data_ready_and_i,
  input  logic [fill_width_p-1:0] dma_data_i,
  input  logic                    dma_data_v_i,
  output logic                    dma_data_yumi_o,
  output logic                    error_o
);

  localparam int OFF_W  = $clog2(fill_width_p / 8);
  localparam int IDX_W  = $clog2(mem_els_p);
  localparam int BEAT_W = $clog2(burst_len_p);
  localparam int CNT_W  = BEAT_W + 1;
  localparam int BLK_W  = IDX_W - BEAT_W;
  localparam int HI_LSB = IDX_W + OFF_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(burst_len_p - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(burst_len_p);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  state_e state_q, state_d;

  // Packet fields: direction and block index (burst-aligned word index >> BEAT_W)
  logic             pkt_wr;
  logic [BLK_W-1:0] pkt_blk;
  assign pkt_wr  = dma_pkt_i[addr_width_p];
  assign pkt_blk = dma_pkt_i[HI_LSB-1:OFF_W+BEAT_W];

  logic [BLK_W-1:0]        blk_q;
  logic [CNT_W-1:0]        iss_q;  // reads issued to the RAM
  logic [CNT_W-1:0]        cnt_q;  // read handshakes or write beats completed
  logic                    v_q;
  logic [fill_width_p-1:0] rdata_q;

  logic             pkt_yumi, rd_en, rd_hs, wr_yumi, we, rd_zero;
  logic [IDX_W-1:0] raddr, waddr;
  logic             pkt_oor, cur_oor;

`ifdef BP_DMA_BRAM_MEM_RANGE_CHECK_EN
  logic oor_q, err_q;
  logic unused_lo_bits;
  assign unused_lo_bits = ^dma_pkt_i[OFF_W+BEAT_W-1:0];
  assign pkt_oor = |dma_pkt_i[addr_width_p-1:HI_LSB];
  assign cur_oor = oor_q;
  assign error_o = err_q;

  // Remember whether the burst in flight is out of range; error is sticky
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      oor_q <= 1'b0;
      err_q <= 1'b0;
    end else if (pkt_yumi) begin
      oor_q <= pkt_oor;
      err_q <= err_q | pkt_oor;
    end
  end
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dma_pkt_i[addr_width_p-1:HI_LSB], dma_pkt_i[OFF_W+BEAT_W-1:0]};
  assign pkt_oor = 1'b0;
  assign cur_oor = 1'b0;
  assign error_o = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: leave a burst on the handshake of its last beat
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pkt_yumi) state_d = pkt_wr ? WRITE : READ;
      READ:    if (rd_hs && cnt_q == LAST) state_d = IDLE;
      WRITE:   if (wr_yumi && cnt_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs per state; the first read is launched in the packet-accept cycle
  always_comb begin
    pkt_yumi = 1'b0;
    wr_yumi  = 1'b0;
    rd_en    = 1'b0;
    case (state_q)
      IDLE: begin
        pkt_yumi = dma_pkt_v_i & ~reset_i;
        rd_en    = pkt_yumi & ~pkt_wr;
      end
      READ:    rd_en   = (iss_q < FULL) & (~v_q | dma_data_ready_and_i);
      WRITE:   wr_yumi = dma_data_v_i & ~reset_i;
      default: ;
    endcase
  end

  assign rd_hs = (state_q == READ) & v_q & dma_data_ready_and_i;

  // Beat address = block index with the beat counter in the low bits
  assign raddr   = (state_q == IDLE) ? {pkt_blk, {BEAT_W{1'b0}}} : {blk_q, iss_q[BEAT_W-1:0]};
  assign waddr   = {blk_q, cnt_q[BEAT_W-1:0]};
  assign rd_zero = (state_q == IDLE) ? pkt_oor : cur_oor;
  assign we      = wr_yumi & ~cur_oor;

  // Burst bookkeeping: latch block, clear counters on accept, count beats
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      blk_q <= '0;
      iss_q <= '0;
      cnt_q <= '0;
      v_q   <= 1'b0;
    end else begin
      v_q <= rd_en | (v_q & ~dma_data_ready_and_i);
      if (pkt_yumi) begin
        blk_q <= pkt_blk;
        iss_q <= pkt_wr ? '0 : CNT_W'(1);
        cnt_q <= '0;
      end else begin
        if (rd_en)            iss_q <= iss_q + CNT_W'(1);
        if (rd_hs || wr_yumi) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  logic [fill_width_p-1:0] mem [mem_els_p];

  // RAM write port; contents survive reset
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= dma_data_i;
  end

  // Synchronous read register; holds while no read is issued
  always_ff @(posedge clk_i) begin
    if (reset_i)    rdata_q <= '0;
    else if (rd_en) rdata_q <= rd_zero ? '0 : mem[raddr];
  end

  assign dma_pkt_yumi_o  = pkt_yumi;
  assign dma_data_yumi_o = wr_yumi;
  assign dma_data_v_o    = v_q;
  assign dma_data_o      = rdata_q;

endmodule

// File: tb/tb_bp_dma_bram_mem.sv
// Directed bench for bp_dma_bram_mem with a read-beat scoreboard.
module tb_bp_dma_bram_mem;

  logic        clk;
  logic        reset;
  logic [28:0] pkt;
  logic        pkt_v;
  logic        pkt_yumi;
  logic [63:0] rd_data;
  logic        rd_v;
  logic        ready;
  logic [63:0] wr_data;
  logic        wr_v;
  logic        wr_yumi;
  logic        err;

  bp_dma_bram_mem dut (
    .clk_i(clk), .reset_i(reset),
    .dma_pkt_i(pkt), .dma_pkt_v_i(pkt_v), .dma_pkt_yumi_o(pkt_yumi),
    .dma_data_o(rd_data), .dma_data_v_o(rd_v), .dma_data_ready_and_i(ready),
    .dma_data_i(wr_data), .dma_data_v_i(wr_v), .dma_data_yumi_o(wr_yumi),
    .error_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  int          checks = 0;
  int          failures = 0;
  logic [63:0] sb [$];
  logic [63:0] model [1024];
  logic        last_pkt_yumi, last_wr_yumi, last_v;
  logic        held_v = 1'b0;
  logic [63:0] held_d;

`ifdef BP_DMA_BRAM_MEM_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at negedge (scoreboard pop, hold check), then advance.
  task automatic tick();
    @(negedge clk);
    last_pkt_yumi = pkt_yumi;
    last_wr_yumi  = wr_yumi;
    last_v        = rd_v;
    if (reset) held_v = 1'b0;
    else begin
      if (held_v) begin
        chk("hold_valid", rd_v, 1'b1);
        chk("hold_data", rd_data, held_d);
      end
      held_v = 1'b0;
      if (rd_v && ready) begin
        checks++;
        assert (sb.size() != 0) else begin
          failures++;
          $error("FAIL extra_beat observed=%h expected=none", rd_data);
        end
        if (sb.size() != 0) chk("rd_beat", rd_data, sb.pop_front());
      end else if (rd_v) begin
        held_v = 1'b1;
        held_d = rd_data;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [27:0] a);
    return int'((a >> 3) & 28'h3F8);
  endfunction

  task automatic push_exp(input logic [27:0] a);
    logic [63:0] e;
    for (int i = 0; i < 8; i++) begin
      e = model[widx(a) + i];
      if (RC && (a >> 13) != 0) e = '0;
      sb.push_back(e);
    end
  endtask

  task automatic pkt_send(input logic wr, input logic [27:0] a);
    pkt   = {wr, a};
    pkt_v = 1'b1;
    tick();
    chk("pkt_yumi", last_pkt_yumi, 1'b1);
    chk("accept_cycle_v", last_v, 1'b0);
    pkt_v = 1'b0;
  endtask

  task automatic write_burst(input logic [27:0] a, input bit seq, input int gap, input bit pend);
    logic [63:0] d;
    pkt_send(1'b1, a);
    if (pend) begin
      pkt   = {1'b0, a};
      pkt_v = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gap; g++) begin
        wr_v = 1'b0;
        tick();
        chk("wr_gap_yumi", last_wr_yumi, 1'b0);
        if (pend) chk("pkt_wait", last_pkt_yumi, 1'b0);
      end
      d = seq ? 64'(i) : {$urandom, $urandom};
      wr_data = d;
      wr_v    = 1'b1;
      tick();
      chk("wr_yumi", last_wr_yumi, 1'b1);
      if (pend) chk("pkt_wait", last_pkt_yumi, 1'b0);
      model[widx(a) + i] = d;
    end
    wr_v = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk({tag, "_valid"}, last_v, 1'b1);
      chk({tag, "_no_wr_yumi"}, last_wr_yumi, 1'b0);
    end
    wr_v = 1'b0;
    tick();
    chk({tag, "_done_v"}, last_v, 1'b0);
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic read_burst(input logic [27:0] a);
    push_exp(a);
    pkt_send(1'b0, a);
    wr_v = 1'b1;  // ignored outside WRITE
    drain("rd");
  endtask

  int n;

  initial begin
    reset = 1'b1; pkt = '0; pkt_v = 1'b0; ready = 1'b1;
    wr_data = '0; wr_v = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_pkt_yumi", pkt_yumi, 1'b0);
    chk("rst_v", rd_v, 1'b0);
    chk("rst_wr_yumi", wr_yumi, 1'b0);
    chk("rst_err", err, 1'b0);

    // Write 0..7 at 0x40, read back with ready held high
    write_burst(28'h40, 1'b1, 0, 1'b0);
    tick();
    read_burst(28'h40);

    // Read with alternating backpressure
    push_exp(28'h40);
    pkt_send(1'b0, 28'h40);
    ready = 1'b1;
    for (int k = 0; k < 40 && sb.size() != 0; k++) begin
      tick();
      ready = ~ready;
    end
    ready = 1'b1;
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Gapped write at 0x80 with a read packet pending behind it
    write_burst(28'h80, 1'b0, 2, 1'b1);
    push_exp(28'h80);
    tick();
    chk("pend_yumi", last_pkt_yumi, 1'b1);
    pkt_v = 1'b0;
    drain("pend_rd");

    // Back-to-back reads: second accepted 9 cycles after the first
    push_exp(28'h40);
    pkt_send(1'b0, 28'h40);
    pkt   = {1'b0, 28'h80};
    pkt_v = 1'b1;
    push_exp(28'h80);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n++;
      if (last_pkt_yumi) break;
    end
    pkt_v = 1'b0;
    chk("b2b_gap", 64'(n), 64'd9);
    drain("b2b_rd");

    // Reset in the middle of a read burst
    write_burst(28'h0, 1'b0, 0, 1'b0);
    push_exp(28'h40);
    for (int i = 0; i < 4; i++) void'(sb.pop_back());
    pkt_send(1'b0, 28'h40);
    for (int i = 0; i < 4; i++) tick();
    chk("mid_sb_empty", 64'(sb.size()), 64'd0);
    reset = 1'b1;
    ready = 1'b0;
    tick();
    reset = 1'b0;
    ready = 1'b1;
    chk("mid_rst_v", rd_v, 1'b0);
    chk("mid_rst_pkt_yumi", pkt_yumi, 1'b0);
    chk("mid_rst_wr_yumi", wr_yumi, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    read_burst(28'h40);

    // Out-of-range read at 0x2000 (zeros + error, or alias of 0x0)
    read_burst(28'h2000);
    chk("oor_err", err, RC);
    read_burst(28'h80);
    chk("oor_err_sticky", err, RC);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("oor_err_cleared", err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
